receiver: RTL and testbench

UART receiver for the serial link. It is the receive-side counterpart of the existing 8N1 transmitter. It deserialises 8N1 frames (start bit, 8 data bits LSB first, 1 stop bit) from the asynchronous RxD pin into bytes for the image-processing datapath. Bytes are presented on a valid/ready handshake, with framing-error and overrun reporting.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/sync_ff.sv | 24 ++
 rtl/receiver.sv | 148 ++++++++++++++
 tb/tb_receiver.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default baud divisor and the
// receive/transmit state encoding.
package uart_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 5208;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_e;

  // Serial data arrives LSB first, so each new bit enters at the MSB end.
  function automatic logic [UART_DATA_BITS-1:0] shift_in_lsb_first(
    input logic [UART_DATA_BITS-1:0] cur,
    input logic                      bit_in
  );
    return {bit_in, cur[UART_DATA_BITS-1:1]};
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for an asynchronous single-bit input; flops preset
// to 1 on reset so an idle-high line reads idle immediately after reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/receiver.sv
// 8N1 UART receiver: synchronises RxD, samples each bit mid-period and
// presents bytes on a valid/ready handshake with framing/overrun reporting.
module receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      RxD,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      valid,
  input  logic                      ready,
  output logic                      frame_error,
  output logic                      overrun,
  output logic                      busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_state_e               state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      fe_q, fe_d;
  logic                      ovr_q, ovr_d;

  logic                      rxs;
  logic                      counting;
  logic                      tick;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_rx_sync (
    .clk   (clk),
    .rst_n (reset),
    .d_i   (RxD),
    .q_o   (rxs)
  );

  // The start check waits half a bit so every later sample lands mid-bit.
  assign counting = (state_q == START) || (state_q == DATA) || (state_q == STOP);
  assign tick     = counting &&
                    (cnt_q == ((state_q == START) ? HALF_M1 : FULL_M1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = valid_q && !ready;
    fe_d      = 1'b0;
    ovr_d     = ovr_q;

    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (rxs) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shreg_d   = shift_in_lsb_first(shreg_q, rxs);
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_BIT) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (rxs) begin
            // Newest byte always wins; losing an unaccepted one is flagged.
            data_d  = shreg_q;
            valid_d = 1'b1;
            if (valid_q && !ready) begin
              ovr_d = 1'b1;
            end
            state_d = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxs) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_d != state_q) || tick) begin
      cnt_d = '0;
    end else if (counting) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ovr_q     <= ovr_d;
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign frame_error = fe_q;
  assign overrun     = ovr_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_receiver.sv
// Bench for the UART receiver: a line-level model predicts data/valid/
// frame_error/overrun every cycle; directed frames pin the model with literals.
module tb_receiver;

  localparam int C    = 16;
  localparam int SYNC = 2;
  localparam int HALF = C / 2;
  // Edge (counted from the start-bit drive) at which a frame's outcome shows.
  localparam int DONE = SYNC + 1 + HALF + 9 * C;
  localparam int HIST = 8192;

  logic       clk = 1'b0;
  logic       reset;
  logic       RxD;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  always #5 clk = ~clk;

  receiver #(
    .CLKS_PER_BIT (C),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .RxD         (RxD),
    .data        (data),
    .valid       (valid),
    .ready       (ready),
    .frame_error (frame_error),
    .overrun     (overrun),
    .busy        (busy)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic       line_hist [HIST];
  int         fall_q [$];
  logic       m_valid = 1'b0;
  logic       m_fe = 1'b0;
  logic       m_ovr = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       prev_ready = 1'b0;
  logic       was_valid;
  logic [7:0] mb;
  int         f;
  int         fe_cnt = 0;
  int         vhigh_cnt = 0;
  logic [7:0] last_data = 8'h00;
  int         v0, f0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model: the line is sampled at the start edge + half a bit + k bit periods.
  always @(negedge clk) begin : model
    if (cyc < HIST) line_hist[cyc] = RxD;
    if (!reset) begin
      fall_q.delete();
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_ovr   = 1'b0;
      m_fe    = 1'b0;
    end else begin
      was_valid = m_valid;
      m_fe = 1'b0;
      if (m_valid && prev_ready) m_valid = 1'b0;
      if (fall_q.size() > 0 && cyc == fall_q[0] + DONE) begin
        f = fall_q.pop_front();
        if (line_hist[f + HALF] == 1'b0) begin
          for (int k = 0; k < 8; k++) mb[k] = line_hist[f + HALF + (k + 1) * C];
          if (line_hist[f + HALF + 9 * C]) begin
            if (was_valid && !prev_ready) m_ovr = 1'b1;
            m_valid = 1'b1;
            m_data  = mb;
          end else begin
            m_fe = 1'b1;
          end
        end
      end
    end
    prev_ready = ready;
    chk("valid", int'(valid), int'(m_valid));
    chk("data", int'(data), int'(m_data));
    chk("frame_error", int'(frame_error), int'(m_fe));
    chk("overrun", int'(overrun), int'(m_ovr));
    if (valid) begin
      vhigh_cnt++;
      last_data = data;
    end
    if (frame_error) fe_cnt++;
  end

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int n);
    @(posedge clk);
    #1 RxD = v;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic start_bit(input int p);
    @(posedge clk);
    #1 RxD = 1'b0;
    fall_q.push_back(cyc);
    repeat (p - 1) @(posedge clk);
  endtask

  task automatic send(input logic [7:0] b, input int p, input logic stop);
    start_bit(p);
    for (int i = 0; i < 8; i++) drive(b[i], p);
    drive(stop, p);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_data"}, int'(data), 0);
    chk({tag, "_fe"}, int'(frame_error), 0);
    chk({tag, "_ovr"}, int'(overrun), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    logic [7:0] b5a;
    reset = 1'b0;
    RxD   = 1'b1;
    ready = 1'b1;
    repeat (3) @(posedge clk);
    settle();
    chk_all_zero("reset");
    @(posedge clk);
    #1 reset = 1'b1;
    drive(1'b1, 10);

    // Clean frame at exact baud
    v0 = vhigh_cnt; f0 = fe_cnt;
    send(8'hA5, C, 1'b1);
    drive(1'b1, 20);
    settle();
    chk("t1_data", int'(last_data), 8'hA5);
    chk("t1_valid_cycles", vhigh_cnt - v0, 1);
    chk("t1_fe", fe_cnt - f0, 0);
    chk("t1_ovr", int'(overrun), 0);
    chk("t1_busy", int'(busy), 0);

    // Short low glitch is rejected at the half-bit check
    v0 = vhigh_cnt;
    start_bit(5);
    settle();
    chk("t3_busy_mid", int'(busy), 1);
    drive(1'b1, 30);
    settle();
    chk("t3_busy_end", int'(busy), 0);
    chk("t3_no_valid", vhigh_cnt - v0, 0);

    // Back-to-back frames with the consumer stalled
    @(posedge clk);
    #1 ready = 1'b0;
    send(8'h00, C, 1'b1);
    send(8'hFF, C, 1'b1);
    drive(1'b1, 10);
    settle();
    chk("t2_valid", int'(valid), 1);
    chk("t2_data", int'(data), 8'hFF);
    chk("t2_ovr", int'(overrun), 1);
    @(posedge clk);
    #1 ready = 1'b1;
    @(posedge clk);
    settle();
    chk("t2_valid_drop", int'(valid), 0);
    chk("t2_ovr_sticky", int'(overrun), 1);

    // Stop bit low followed by a held-low line
    v0 = vhigh_cnt; f0 = fe_cnt;
    send(8'h3C, C, 1'b0);
    drive(1'b0, 40);
    settle();
    chk("t4_fe_once", fe_cnt - f0, 1);
    chk("t4_busy_break", int'(busy), 1);
    chk("t4_no_valid", vhigh_cnt - v0, 0);
    drive(1'b1, 30);
    settle();
    chk("t4_busy_idle", int'(busy), 0);
    send(8'h81, C, 1'b1);
    drive(1'b1, 20);
    settle();
    chk("t4_data", int'(last_data), 8'h81);
    chk("t4_fe_total", fe_cnt - f0, 1);
    chk("t4_valid_cycles", vhigh_cnt - v0, 1);

    // Reset during the fourth data bit of 0x5A
    b5a = 8'h5A;
    start_bit(C);
    for (int i = 0; i < 3; i++) drive(b5a[i], C);
    drive(b5a[3], 8);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    settle();
    chk_all_zero("t5_in_reset");
    @(posedge clk);
    #1 reset = 1'b1;
    drive(1'b1, 30);
    v0 = vhigh_cnt; f0 = fe_cnt;
    send(8'h12, C, 1'b1);
    drive(1'b1, 20);
    settle();
    chk("t5_data", int'(last_data), 8'h12);
    chk("t5_valid_cycles", vhigh_cnt - v0, 1);
    chk("t5_fe", fe_cnt - f0, 0);
    chk("t5_ovr", int'(overrun), 0);

    // Off-nominal bit periods
    v0 = vhigh_cnt; f0 = fe_cnt;
    send(8'h96, 17, 1'b1);
    drive(1'b1, 30);
    settle();
    chk("t6_p17_data", int'(last_data), 8'h96);
    chk("t6_p17_valid", vhigh_cnt - v0, 1);
    chk("t6_p17_fe", fe_cnt - f0, 0);
    v0 = vhigh_cnt;
    send(8'h96, 15, 1'b1);
    drive(1'b1, 30);
    settle();
    chk("t6_p15_valid", vhigh_cnt - v0, 1);
    chk("t6_p15_fe", fe_cnt - f0, 0);
    chk("t6_busy", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
